// File: rtl/cmp_pkg.sv
// Shared types for the multi-lane comparator: one-hot compare result and lock FSM states.
package cmp_pkg;

    localparam int unsigned CMP_W = 3;

    typedef enum logic [2:0] {
        CMP_LT = 3'b001,
        CMP_EQ = 3'b010,
        CMP_GT = 3'b100
    } cmp_res_t;

    typedef enum logic [1:0] {
        IDLE,
        MATCH,
        LOCK
    } lock_state_t;

    // Collapse lt/gt flags into the one-hot result; neither set means equal.
    function automatic cmp_res_t cmp_encode(input logic lt, input logic gt);
        cmp_res_t r;
        if (lt)      r = CMP_LT;
        else if (gt) r = CMP_GT;
        else         r = CMP_EQ;
        return r;
    endfunction

endpackage

// File: rtl/cmp_pipe_lock_if.sv
// Operand/result valid-ready bus of cmp_pipe_lock; slave is the comparator side.
interface cmp_pipe_lock_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 2
);
    import cmp_pkg::*;

    localparam int unsigned DW    = LANES * WIDTH;
    localparam int unsigned RES_W = LANES * CMP_W;

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] res;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, res
    );

endinterface

// File: rtl/cmp_lane.sv
// Single-lane combinational magnitude compare; signed path exists only with CMP_SIGNED_EN.
module cmp_lane
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    logic lt;
    logic gt;

    always_comb begin
        lt = a < b;
        gt = a > b;
`ifdef CMP_SIGNED_EN
        if (signed_mode) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end
`endif
        res = cmp_encode(lt, gt);
    end

endmodule

// File: rtl/cmp_pipe_lock.sv
// Multi-lane comparator with 2-stage valid/ready pipe, sticky GT/LT flags and all-equal lock FSM.
// Define CMP_SIGNED_EN to honour the per-beat signed_mode input.
module cmp_pipe_lock
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LANES  = 2,
    parameter int unsigned LOCK_N = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    cmp_pipe_lock_if.slave   bus,
    input  logic             clr_sticky,
    output logic             sticky_gt,
    output logic             sticky_lt,
    output logic [CNT_W-1:0] eq_run,
    output logic             lock
);

    localparam int unsigned DW    = LANES * WIDTH;
    localparam int unsigned RES_W = LANES * CMP_W;
    localparam int unsigned RUN_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] RUN_MAX = '1;

    logic             s1_valid;
    logic [DW-1:0]    s1_a;
    logic [DW-1:0]    s1_b;
`ifdef CMP_SIGNED_EN
    logic             s1_signed;
`endif
    logic             s2_valid;
    logic [RES_W-1:0] res_q;
    logic [RES_W-1:0] res_d;
    cmp_res_t         lane_res [LANES];

    logic s2_can_load_c;
    logic in_ready_c;
    logic hs_c;
    logic all_eq_c;
    logic any_gt_c;
    logic any_lt_c;
    logic [RUN_W-1:0] run_next_c;

    lock_state_t state_q;
    lock_state_t state_d;

    assign s2_can_load_c = !s2_valid || bus.out_ready;
    assign in_ready_c    = !nRST && (!s1_valid || s2_can_load_c);
    assign hs_c          = s2_valid && bus.out_ready;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = s2_valid;
    assign bus.res       = res_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cmp_lane #(.WIDTH(WIDTH)) u_lane (
`ifdef CMP_SIGNED_EN
            .signed_mode (s1_signed),
`endif
            .a           (s1_a[i*WIDTH +: WIDTH]),
            .b           (s1_b[i*WIDTH +: WIDTH]),
            .res         (lane_res[i])
        );
    end

    always_comb begin
        res_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            res_d[i*CMP_W +: CMP_W] = lane_res[i];
        end
    end

    // S1 holds operands while S2 is stalled; S2 holds the result until the consumer takes it.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
`ifdef CMP_SIGNED_EN
            s1_signed <= 1'b0;
`endif
            s2_valid  <= 1'b0;
            res_q     <= '0;
        end else begin
            if (in_ready_c) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a      <= bus.a;
                    s1_b      <= bus.b;
`ifdef CMP_SIGNED_EN
                    s1_signed <= bus.signed_mode;
`endif
                end
            end
            if (s2_can_load_c) begin
                s2_valid <= s1_valid;
                if (s1_valid) res_q <= res_d;
            end
        end
    end

    always_comb begin
        all_eq_c = 1'b1;
        any_gt_c = 1'b0;
        any_lt_c = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            all_eq_c = all_eq_c & res_q[i*CMP_W + 1];
            any_gt_c = any_gt_c | res_q[i*CMP_W + 2];
            any_lt_c = any_lt_c | res_q[i*CMP_W];
        end
    end

    // A set on the handshake outranks a coincident clear.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            sticky_gt <= 1'b0;
            sticky_lt <= 1'b0;
            eq_run    <= '0;
        end else begin
            if (hs_c && any_gt_c) sticky_gt <= 1'b1;
            else if (clr_sticky)  sticky_gt <= 1'b0;
            if (hs_c && any_lt_c) sticky_lt <= 1'b1;
            else if (clr_sticky)  sticky_lt <= 1'b0;
            if (hs_c) begin
                if (!all_eq_c)             eq_run <= '0;
                else if (eq_run != RUN_MAX) eq_run <= eq_run + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q <= IDLE;
            lock    <= 1'b0;
        end else begin
            state_q <= state_d;
            lock    <= (state_d == LOCK);
        end
    end

    always_comb begin
        state_d    = state_q;
        run_next_c = RUN_W'(eq_run) + RUN_W'(1);
        if (hs_c) begin
            case (state_q)
                IDLE:    if (all_eq_c) state_d = (LOCK_N == 1) ? LOCK : MATCH;
                MATCH: begin
                    if (!all_eq_c)                        state_d = IDLE;
                    else if (run_next_c == RUN_W'(LOCK_N)) state_d = LOCK;
                end
                LOCK:    if (!all_eq_c) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_pipe_lock.sv
// Scoreboard bench for cmp_pipe_lock; honours CMP_SIGNED_EN the same way as the design.
module tb_cmp_pipe_lock;
    import cmp_pkg::*;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned LANES  = 2;
    localparam int unsigned LOCK_N = 3;
    localparam int unsigned CNT_W  = 4;
`ifdef CMP_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             nRST = 1'b1;
    logic             clr_sticky = 1'b0;
    logic             sticky_gt;
    logic             sticky_lt;
    logic [CNT_W-1:0] eq_run;
    logic             lock;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;

    logic [5:0] exp_q [$];
    logic [5:0] exp_v;
    logic [5:0] stall_res;
    logic       stall_pending = 1'b0;

    cmp_pipe_lock_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    cmp_pipe_lock #(
        .WIDTH(WIDTH), .LANES(LANES), .LOCK_N(LOCK_N), .CNT_W(CNT_W)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus),
        .clr_sticky (clr_sticky),
        .sticky_gt  (sticky_gt),
        .sticky_lt  (sticky_lt),
        .eq_run     (eq_run),
        .lock       (lock)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] model(input logic [15:0] av, input logic [15:0] bv, input logic sm);
        logic [5:0] r;
        logic [7:0] x;
        logic [7:0] y;
        logic lt;
        logic gt;
        logic use_s;
        r = '0;
        use_s = sm & SIGNED_EN;
        for (int l = 0; l < 2; l++) begin
            x = av[l*8 +: 8];
            y = bv[l*8 +: 8];
            if (use_s) begin
                lt = $signed(x) < $signed(y);
                gt = $signed(x) > $signed(y);
            end else begin
                lt = x < y;
                gt = x > y;
            end
            r[l*3 +: 3] = lt ? 3'b001 : (gt ? 3'b100 : 3'b010);
        end
        return r;
    endfunction

    // Output monitor: inputs only change just after posedge, so negedge sees the values the next edge will use.
    always @(negedge CLK) begin
        if (nRST) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.res !== stall_res) begin
                    bad++;
                    $display("FAIL stall_hold: out_valid=%b res=%b required out_valid=1 res=%b",
                             bus.out_valid, bus.res, stall_res);
                end
            end
            if (bus.out_valid === 1'b1) begin
                if (bus.out_ready === 1'b1) begin
                    stall_pending = 1'b0;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat: res=%b with empty scoreboard", bus.res);
                    end else begin
                        exp_v = exp_q.pop_front();
                        n_pop++;
                        if (bus.res !== exp_v) begin
                            bad++;
                            $display("FAIL res_scoreboard: got %b required %b", bus.res, exp_v);
                        end
                    end
                end else begin
                    stall_pending = 1'b1;
                    stall_res     = bus.res;
                end
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sm);
        logic acc;
        acc = 1'b0;
        bus.a           = av;
        bus.b           = bv;
        bus.signed_mode = sm;
        bus.in_valid    = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge CLK);
            acc = bus.in_ready;
            @(posedge CLK);
            #1;
        end
        bus.in_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b required 1 within 100 cycles", bus.in_ready);
        end else begin
            exp_q.push_back(model(av, bv, sm));
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick();
            done = (exp_q.size() == 0) && (bus.out_valid === 1'b0);
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d out_valid=%b required 0 and 0", exp_q.size(), bus.out_valid);
        end
    endtask

    task automatic clear_sticky();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        nRST            = 1'b1;
        tick();
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.res !== 6'b0) begin
            bad++;
            $display("FAIL reset_out: out_valid=%b res=%b required 0 and 000000", bus.out_valid, bus.res);
        end
        total++;
        if (sticky_gt !== 1'b0 || sticky_lt !== 1'b0) begin
            bad++;
            $display("FAIL reset_sticky: gt=%b lt=%b required 0 0", sticky_gt, sticky_lt);
        end
        total++;
        if (eq_run !== 4'd0 || lock !== 1'b0) begin
            bad++;
            $display("FAIL reset_lock: eq_run=%0d lock=%b required 0 0", eq_run, lock);
        end
        total++;
        if (dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL reset_state: state=%0d required IDLE", dut.state_q);
        end
        nRST = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_latency();
        bus.out_ready = 1'b1;
        send(16'h05F0, 16'h0510, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: out_valid=%b required 0", bus.out_valid);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.res !== 6'b010_100) begin
            bad++;
            $display("FAIL latency_res: out_valid=%b res=%b required 1 010100", bus.out_valid, bus.res);
        end
        tick();
        total++;
        if (sticky_gt !== 1'b1 || sticky_lt !== 1'b0 || eq_run !== 4'd0) begin
            bad++;
            $display("FAIL latency_stats: gt=%b lt=%b eq_run=%0d required 1 0 0", sticky_gt, sticky_lt, eq_run);
        end
    endtask

    task automatic test_signed();
        clear_sticky();
        total++;
        if (sticky_gt !== 1'b0 || sticky_lt !== 1'b0) begin
            bad++;
            $display("FAIL clear_sticky: gt=%b lt=%b required 0 0", sticky_gt, sticky_lt);
        end
        send(16'h05F0, 16'h0510, 1'b1);
        drain();
        total++;
        if (sticky_lt !== SIGNED_EN || sticky_gt !== !SIGNED_EN) begin
            bad++;
            $display("FAIL signed_sticky: gt=%b lt=%b required %b %b", sticky_gt, sticky_lt, !SIGNED_EN, SIGNED_EN);
        end
    endtask

    task automatic test_backpressure();
        int pop0;
        logic pat [4];
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        pop0 = n_pop;
        fork
            begin
                for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    bus.out_ready = pat[k % 4];
                    tick();
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        total++;
        if (n_pop - pop0 != 5) begin
            bad++;
            $display("FAIL backpressure_count: popped %0d required 5", n_pop - pop0);
        end
    endtask

    task automatic test_lock();
        logic [15:0] v;
        nRST = 1'b1;
        tick();
        nRST = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v = 16'($urandom);
            send(v, v, 1'b0);
        end
        drain();
        total++;
        if (eq_run !== 4'd2 || lock !== 1'b0) begin
            bad++;
            $display("FAIL lock_two: eq_run=%0d lock=%b required 2 0", eq_run, lock);
        end
        send(16'h3C3C, 16'h3C3C, 1'b0);
        drain();
        total++;
        if (eq_run !== 4'd3 || lock !== 1'b1) begin
            bad++;
            $display("FAIL lock_three: eq_run=%0d lock=%b required 3 1", eq_run, lock);
        end
        send(16'h0101, 16'h0202, 1'b0);
        drain();
        total++;
        if (eq_run !== 4'd0 || lock !== 1'b0 || sticky_lt !== 1'b1) begin
            bad++;
            $display("FAIL lock_break: eq_run=%0d lock=%b lt=%b required 0 0 1", eq_run, lock, sticky_lt);
        end
        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom);
            send(v, v, 1'b0);
        end
        drain();
        total++;
        if (eq_run !== 4'd15 || lock !== 1'b1) begin
            bad++;
            $display("FAIL lock_saturate: eq_run=%0d lock=%b required 15 1", eq_run, lock);
        end
    endtask

    task automatic test_simultaneous();
        logic seen;
        bus.out_ready = 1'b1;
        clear_sticky();
        total++;
        if (sticky_gt !== 1'b0) begin
            bad++;
            $display("FAIL sim_pre_clear: gt=%b required 0", sticky_gt);
        end
        send(16'h0003, 16'h0001, 1'b0);
        tick();
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL sim_valid: out_valid=%b required 1", bus.out_valid);
        end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total++;
        if (sticky_gt !== 1'b1) begin
            bad++;
            $display("FAIL sim_set_wins: gt=%b required 1", sticky_gt);
        end
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0);
        send(16'h5555, 16'h5555, 1'b0);
        nRST = 1'b1;
        tick();
        nRST = 1'b0;
        exp_q.delete();
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_flush: out_valid seen=%b required 0", seen);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_signed();
        test_backpressure();
        test_lock();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
